// File: rtl/acc_mem_pkg.sv
// Shared types for the accelerator memory arbiter: grant state encoding,
// owner tag width and the response FIFO entry layout.
package acc_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_GNT0 = 2'b01,
        ST_GNT1 = 2'b10
    } gnt_state_e;

    localparam int CLIENT_W   = 1;
    localparam int ACC_ADDR_W = 32;
    localparam int ACC_DATA_W = 32;

    typedef struct packed {
        logic [ACC_ADDR_W-1:0] addr;
        logic [ACC_DATA_W-1:0] data;
    } rsp_entry_t;

endpackage

// File: rtl/acc_mem_arbiter_if.sv
// One BIU client link: request side (req/addr/vld/rdy) and response side
// (rsp_addr/rsp_data/rsp_vld/rsp_rdy).
interface acc_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              vld;
    logic              rdy;
    logic [ADDR_W-1:0] rsp_addr;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_vld;
    logic              rsp_rdy;

    modport master (
        output req, addr, vld, rsp_rdy,
        input  rdy, rsp_addr, rsp_data, rsp_vld
    );

    modport slave (
        input  req, addr, vld, rsp_rdy,
        output rdy, rsp_addr, rsp_data, rsp_vld
    );
endinterface

// File: rtl/acc_rsp_fifo.sv
// Synchronous show-ahead response FIFO; the head entry is read straight from
// the storage registers and forced to zero while the FIFO is empty.
module acc_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [W-1:0]             din_i,
    input  logic                     pop_i,
    output logic [W-1:0]             dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);
    assign count_o = cnt_q;
    assign dout_o  = empty_o ? '0 : mem_q[rptr_q];
endmodule

// File: rtl/acc_mem_arbiter.sv
// Two-client read arbiter onto a fixed-latency memory port: grant FSM,
// owner-tagged read pipeline, per-client credits and response FIFOs.
module acc_mem_arbiter
    import acc_mem_pkg::*;
#(
    parameter int ADDR_W = ACC_ADDR_W,
    parameter int DATA_W = ACC_DATA_W,
    parameter int RD_LAT = 2,
    parameter int OSTD   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    acc_mem_arbiter_if.slave  c0,
    acc_mem_arbiter_if.slave  c1,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int CRED_W = $clog2(OSTD + 1);
    localparam int CNT_W  = $clog2(OSTD) + 1;
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(OSTD);

    gnt_state_e          state_q;
    logic                last_q;
    logic [CRED_W-1:0]   cred0_q, cred0_d;
    logic [CRED_W-1:0]   cred1_q, cred1_d;
    logic                acc0, acc1, pop0, pop1, push0, push1;
    logic [RD_LAT-1:0]   tag_vld_q;
    logic [CLIENT_W-1:0] tag_own_q  [RD_LAT];
    logic [ADDR_W-1:0]   tag_addr_q [RD_LAT];
    rsp_entry_t          push_ent, head0, head1;
    logic                full0, full1, empty0, empty1;
    logic [CNT_W-1:0]    cnt0, cnt1;

    // Grant FSM; last_q remembers who was served last for the tie-break.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (c0.req && (!c1.req || last_q)) begin
                        state_q <= ST_GNT0;
                        last_q  <= 1'b0;
                    end else if (c1.req) begin
                        state_q <= ST_GNT1;
                        last_q  <= 1'b1;
                    end
                end
                ST_GNT0: begin
                    if (!c0.req) begin
                        state_q <= c1.req ? ST_GNT1 : ST_IDLE;
                        if (c1.req) last_q <= 1'b1;
                    end
                end
                ST_GNT1: begin
                    if (!c1.req) begin
                        state_q <= c0.req ? ST_GNT0 : ST_IDLE;
                        if (c0.req) last_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign c0.rdy  = (state_q == ST_GNT0) && (cred0_q < CRED_MAX);
    assign c1.rdy  = (state_q == ST_GNT1) && (cred1_q < CRED_MAX);
    assign acc0    = c0.vld && c0.rdy;
    assign acc1    = c1.vld && c1.rdy;
    assign mem_ren = acc0 || acc1;

    always_comb begin
        mem_raddr = '0;
        if (state_q == ST_GNT0)      mem_raddr = c0.addr;
        else if (state_q == ST_GNT1) mem_raddr = c1.addr;
    end

    // Credits cover beats in the tag pipeline plus beats waiting in the FIFO.
    always_comb begin
        cred0_d = cred0_q;
        if (acc0 && !pop0)      cred0_d = cred0_q + CRED_W'(1);
        else if (!acc0 && pop0) cred0_d = cred0_q - CRED_W'(1);
        cred1_d = cred1_q;
        if (acc1 && !pop1)      cred1_d = cred1_q + CRED_W'(1);
        else if (!acc1 && pop1) cred1_d = cred1_q - CRED_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cred0_q   <= '0;
            cred1_q   <= '0;
            tag_vld_q <= '0;
        end else begin
            cred0_q      <= cred0_d;
            cred1_q      <= cred1_d;
            tag_vld_q[0] <= mem_ren;
            for (int i = 1; i < RD_LAT; i++) tag_vld_q[i] <= tag_vld_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        tag_own_q[0]  <= CLIENT_W'(acc1);
        tag_addr_q[0] <= mem_raddr;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_own_q[i]  <= tag_own_q[i-1];
            tag_addr_q[i] <= tag_addr_q[i-1];
        end
    end

    assign push_ent = '{addr: tag_addr_q[RD_LAT-1], data: mem_rdata};
    assign push0    = tag_vld_q[RD_LAT-1] && (tag_own_q[RD_LAT-1] == CLIENT_W'(0));
    assign push1    = tag_vld_q[RD_LAT-1] && (tag_own_q[RD_LAT-1] == CLIENT_W'(1));
    assign pop0     = c0.rsp_vld && c0.rsp_rdy;
    assign pop1     = c1.rsp_vld && c1.rsp_rdy;

    acc_rsp_fifo #(.DEPTH(OSTD), .W($bits(rsp_entry_t))) u_fifo0 (
        .clk(clk), .rst_n(rst_n), .push_i(push0), .din_i(push_ent), .pop_i(pop0),
        .dout_o(head0), .full_o(full0), .empty_o(empty0), .count_o(cnt0)
    );

    acc_rsp_fifo #(.DEPTH(OSTD), .W($bits(rsp_entry_t))) u_fifo1 (
        .clk(clk), .rst_n(rst_n), .push_i(push1), .din_i(push_ent), .pop_i(pop1),
        .dout_o(head1), .full_o(full1), .empty_o(empty1), .count_o(cnt1)
    );

    assign c0.rsp_vld  = !empty0;
    assign c0.rsp_addr = head0.addr;
    assign c0.rsp_data = head0.data;
    assign c1.rsp_vld  = !empty1;
    assign c1.rsp_addr = head1.addr;
    assign c1.rsp_data = head1.data;

    // Credits bound the FIFO occupancy, so a push into a full FIFO is a logic bug.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push0 && full0));
            assert (!(push1 && full1));
            assert (32'(cnt0) <= 32'(cred0_q));
            assert (32'(cnt1) <= 32'(cred1_q));
        end
    end
endmodule

// File: tb/tb_acc_mem_arbiter.sv
// Randomized bench for acc_mem_arbiter against a queue-based reference model.
module tb_acc_mem_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 2;
    localparam int OSTD   = 4;

    typedef struct {
        logic [31:0] a;
        longint      t;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              mem_ren;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] rd_pipe [RD_LAT] = '{default: '0};

    int     total = 0;
    int     bad = 0;
    bit     started = 1'b0;
    longint cyc = 0;
    int     own = -1;
    int     last = 1;
    int     nxt;
    int     acc_n0 = 0;
    int     acc_n1 = 0;
    ent_t   q0[$];
    ent_t   q1[$];
    int     glog[$];
    bit     e_rdy0, e_rdy1, e_v0, e_v1;
    logic [31:0] e_raddr;

    acc_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if_c0 ();
    acc_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if_c1 ();

    acc_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .OSTD(OSTD)) dut (
        .clk(clk), .rst_n(rst_n), .c0(if_c0), .c1(if_c1),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    // Memory: data for an address read in cycle t appears in cycle t+RD_LAT; garbage otherwise.
    always @(posedge clk) begin
        for (int i = RD_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= mem_ren ? mdata(mem_raddr) : $urandom;
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: credits are the number of accepted-but-unpopped beats per client.
    always @(negedge clk) begin
        if (started) begin
            cyc++;
            e_rdy0  = (own == 0) && (q0.size() < OSTD);
            e_rdy1  = (own == 1) && (q1.size() < OSTD);
            e_v0    = (q0.size() > 0) && (q0[0].t + RD_LAT + 1 <= cyc);
            e_v1    = (q1.size() > 0) && (q1[0].t + RD_LAT + 1 <= cyc);
            e_raddr = (own == 0) ? if_c0.addr : (own == 1) ? if_c1.addr : 32'h0;
            chk("c0_rdy", 64'(if_c0.rdy), 64'(e_rdy0));
            chk("c1_rdy", 64'(if_c1.rdy), 64'(e_rdy1));
            chk("mem_ren", 64'(mem_ren), 64'((e_rdy0 && if_c0.vld) || (e_rdy1 && if_c1.vld)));
            chk("mem_raddr", 64'(mem_raddr), 64'(e_raddr));
            chk("c0_rsp_vld", 64'(if_c0.rsp_vld), 64'(e_v0));
            chk("c1_rsp_vld", 64'(if_c1.rsp_vld), 64'(e_v1));
            if (e_v0) begin
                chk("c0_rsp_addr", 64'(if_c0.rsp_addr), 64'(q0[0].a));
                chk("c0_rsp_data", 64'(if_c0.rsp_data), 64'(mdata(q0[0].a)));
            end
            if (e_v1) begin
                chk("c1_rsp_addr", 64'(if_c1.rsp_addr), 64'(q1[0].a));
                chk("c1_rsp_data", 64'(if_c1.rsp_data), 64'(mdata(q1[0].a)));
            end
            if (!rst_n) begin
                q0.delete();
                q1.delete();
                own  = -1;
                last = 1;
            end else begin
                if (e_v0 && if_c0.rsp_rdy) void'(q0.pop_front());
                if (e_v1 && if_c1.rsp_rdy) void'(q1.pop_front());
                if (e_rdy0 && if_c0.vld) begin q0.push_back('{if_c0.addr, cyc}); acc_n0++; end
                if (e_rdy1 && if_c1.vld) begin q1.push_back('{if_c1.addr, cyc}); acc_n1++; end
                nxt = own;
                if (own == 0 && !if_c0.req)      nxt = if_c1.req ? 1 : -1;
                else if (own == 1 && !if_c1.req) nxt = if_c0.req ? 0 : -1;
                else if (own == -1) begin
                    if (if_c0.req && if_c1.req) nxt = (last == 0) ? 1 : 0;
                    else if (if_c0.req)         nxt = 0;
                    else if (if_c1.req)         nxt = 1;
                end
                if (nxt != own && nxt != -1) begin
                    glog.push_back(nxt);
                    last = nxt;
                end
                own = nxt;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_zero(input string tag);
        @(negedge clk);
        chk({tag, "_c0_rdy"}, 64'(if_c0.rdy), 64'd0);
        chk({tag, "_c1_rdy"}, 64'(if_c1.rdy), 64'd0);
        chk({tag, "_c0_rsp"}, {if_c0.rsp_vld, if_c0.rsp_addr, if_c0.rsp_data[30:0]}, 64'd0);
        chk({tag, "_c1_rsp"}, {if_c1.rsp_vld, if_c1.rsp_addr, if_c1.rsp_data[30:0]}, 64'd0);
        chk({tag, "_mem"}, {31'd0, mem_ren, mem_raddr}, 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic burst(input int n, input logic [31:0] base, input int beats, input bit drop);
        int i;
        int guard;
        bit hs;
        i = 0;
        guard = 0;
        if (n == 0) if_c0.req = 1'b1; else if_c1.req = 1'b1;
        while (i < beats && guard < 300) begin
            if (n == 0) begin if_c0.vld = 1'b1; if_c0.addr = base + 32'(4 * i); end
            else        begin if_c1.vld = 1'b1; if_c1.addr = base + 32'(4 * i); end
            @(negedge clk);
            hs = (n == 0) ? if_c0.rdy : if_c1.rdy;
            @(posedge clk);
            #1;
            if (hs) i++;
            guard++;
        end
        chk($sformatf("burst%0d_beats", n), 64'(i), 64'(beats));
        if (n == 0) begin if_c0.vld = 1'b0; if (drop) if_c0.req = 1'b0; end
        else        begin if_c1.vld = 1'b0; if (drop) if_c1.req = 1'b0; end
    endtask

    int gs;
    int base1;

    initial begin
        // Reset with every input high
        rst_n = 1'b0;
        if_c0.req = 1'b1; if_c0.vld = 1'b1; if_c0.addr = '1; if_c0.rsp_rdy = 1'b1;
        if_c1.req = 1'b1; if_c1.vld = 1'b1; if_c1.addr = '1; if_c1.rsp_rdy = 1'b1;
        @(posedge clk);
        #1;
        started = 1'b1;
        step(2);
        chk_zero("rst");
        rst_n = 1'b1;
        chk_zero("post_rst");
        @(negedge clk);
        chk("first_gnt_c0", 64'(if_c0.rdy), 64'd1);
        chk("first_gnt_c1", 64'(if_c1.rdy), 64'd0);
        @(posedge clk);
        #1;
        if_c0.req = 1'b0; if_c0.vld = 1'b0;
        if_c1.req = 1'b0; if_c1.vld = 1'b0;
        step(8);

        // Single-client burst
        burst(0, 32'h100, 8, 1'b1);
        step(10);

        // Backpressure on client 1
        if_c1.rsp_rdy = 1'b0;
        base1 = acc_n1;
        fork
            burst(1, 32'h400, 10, 1'b1);
            begin
                step(20);
                chk("bp_accepted", 64'(acc_n1 - base1), 64'(OSTD));
                @(negedge clk);
                chk("bp_c1_rdy_low", 64'(if_c1.rdy), 64'd0);
                @(posedge clk);
                #1;
                if_c1.rsp_rdy = 1'b1;
            end
        join
        step(10);

        // Contention: client 0 drops after 4 beats, client 1 takes over
        gs = glog.size();
        fork
            burst(0, 32'h200, 4, 1'b1);
            burst(1, 32'h300, 4, 1'b1);
        join
        step(10);
        chk("cont_gnt_cnt", 64'(glog.size() - gs), 64'd2);
        if (glog.size() >= gs + 2) begin
            chk("cont_gnt_first", 64'(glog[gs]), 64'd0);
            chk("cont_gnt_second", 64'(glog[gs+1]), 64'd1);
        end

        // Round-robin from IDLE with both requesting
        gs = glog.size();
        for (int r = 0; r < 4; r++) begin
            if_c0.req = 1'b1; if_c1.req = 1'b1;
            step(3);
            if_c0.req = 1'b0; if_c1.req = 1'b0;
            step(2);
        end
        chk("rr_gnt_cnt", 64'(glog.size() - gs), 64'd4);
        if (glog.size() >= gs + 4)
            for (int r = 0; r < 4; r++) chk($sformatf("rr_gnt%0d", r), 64'(glog[gs+r]), 64'(r % 2));

        // Reset with beats outstanding, then a fresh burst must see full credits
        if_c0.rsp_rdy = 1'b0;
        burst(0, 32'h500, 3, 1'b0);
        rst_n = 1'b0;
        step(2);
        if_c0.req = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("mid_rst_no_rsp", 64'(if_c0.rsp_vld), 64'd0);
            @(posedge clk);
            #1;
        end
        burst(0, 32'h600, OSTD, 1'b1);
        if_c0.rsp_rdy = 1'b1;
        step(10);

        // Random traffic
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(15) == 0) if_c0.req = ~if_c0.req;
            if ($urandom_range(15) == 0) if_c1.req = ~if_c1.req;
            if_c0.vld     = 1'($urandom_range(1));
            if_c1.vld     = 1'($urandom_range(1));
            if_c0.addr    = $urandom;
            if_c1.addr    = $urandom;
            if_c0.rsp_rdy = ((k / 200) % 2 == 0) ? ($urandom_range(3) != 0) : ($urandom_range(5) == 0);
            if_c1.rsp_rdy = ($urandom_range(2) != 0);
            rst_n         = ($urandom_range(299) != 0);
            step(1);
        end
        rst_n = 1'b1;
        if_c0.req = 1'b0; if_c0.vld = 1'b0; if_c0.rsp_rdy = 1'b1;
        if_c1.req = 1'b0; if_c1.vld = 1'b0; if_c1.rsp_rdy = 1'b1;
        step(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
